// File: rtl/xnor_gate_pipe.sv
// Gated bitwise logic unit with a 2-entry output FIFO behind valid/ready handshakes.
// Optional XNOR_GATE_PIPE_REDUCE_EN adds per-entry y_zero/y_par reduction outputs.
module xnor_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] beat_cnt
`ifdef XNOR_GATE_PIPE_REDUCE_EN
  ,
  output logic             y_zero,
  output logic             y_par
`endif
);

  logic [WIDTH-1:0] func_res;
  logic [WIDTH-1:0] mem [2];
  logic [WIDTH-1:0] last_y;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  always_comb begin
    func_res = '0;
    if (en) begin
      case (op)
        3'd0: func_res = a & b;
        3'd1: func_res = a | b;
        3'd2: func_res = a ^ b;
        3'd3: func_res = ~(a ^ b);
        3'd4: func_res = ~(a & b);
        3'd5: func_res = ~(a | b);
        3'd6: func_res = a;
        default: func_res = ~a;
      endcase
    end
  end

  // in_ready comes only from the registered count, so out_ready never reaches it combinationally
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      last_y   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      beat_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= func_res;
        wr_ptr      <= ~wr_ptr;
        beat_cnt    <= beat_cnt + 1'b1;
      end
      if (pop) begin
        last_y <= mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // When empty, the head slot is stale, so the last popped value is shown instead
  assign y = out_valid ? mem[rd_ptr] : last_y;

`ifdef XNOR_GATE_PIPE_REDUCE_EN
  logic mem_zero [2];
  logic mem_par  [2];
  logic last_zero;
  logic last_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_zero[0] <= 1'b1;
      mem_zero[1] <= 1'b1;
      mem_par[0]  <= 1'b0;
      mem_par[1]  <= 1'b0;
      last_zero   <= 1'b1;
      last_par    <= 1'b0;
    end else begin
      if (push) begin
        mem_zero[wr_ptr] <= ~|func_res;
        mem_par[wr_ptr]  <= ^func_res;
      end
      if (pop) begin
        last_zero <= mem_zero[rd_ptr];
        last_par  <= mem_par[rd_ptr];
      end
    end
  end

  assign y_zero = out_valid ? mem_zero[rd_ptr] : last_zero;
  assign y_par  = out_valid ? mem_par[rd_ptr]  : last_par;
`endif

endmodule

// File: tb/tb_xnor_gate_pipe.sv
// Directed self-checking bench for xnor_gate_pipe (WIDTH=8, CNT_W=4 so the counter wrap is reachable).
module tb_xnor_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] beat_cnt;
`ifdef XNOR_GATE_PIPE_REDUCE_EN
  logic       y_zero;
  logic       y_par;
`endif

  int errors = 0;
  int checks = 0;

  xnor_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op(op),
    .en(en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .beat_cnt(beat_cnt)
`ifdef XNOR_GATE_PIPE_REDUCE_EN
    ,
    .y_zero(y_zero),
    .y_par(y_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the falling edge, then drives one beat (outputs are checked at falling edges too)
  task automatic apply_stimulus(input logic v, input logic [7:0] ai, input logic [7:0] bi,
                                input logic [2:0] opi, input logic eni, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    a         = ai;
    b         = bi;
    op        = opi;
    en        = eni;
    out_ready = rdy;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h24, 8'hBD, 8'h99, 8'h66, 8'hDB, 8'h42, 8'hA5, 8'h5A};
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; en = 1'b0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_y", 64'(y), 64'h0);
    check_output("rst_beat_cnt", 64'(beat_cnt), 64'd0);
`ifdef XNOR_GATE_PIPE_REDUCE_EN
    check_output("rst_y_zero", 64'(y_zero), 64'd1);
    check_output("rst_y_par", 64'(y_par), 64'd0);
`endif
    rst_n = 1'b1;

    // Function sweep: each result visible one cycle after its push
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 8'hA5, 8'h3C, 3'(i), 1'b1, 1'b1);
      if (i > 0) begin
        check_output($sformatf("sweep_y_op%0d", i - 1), 64'(y), 64'(sweep_exp[i-1]));
        check_output($sformatf("sweep_valid_op%0d", i - 1), 64'(out_valid), 64'd1);
      end
    end
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    check_output("sweep_y_op7", 64'(y), 64'h5A);
    apply_stimulus(1'b0, 8'hFF, 8'hFF, 3'd3, 1'b1, 1'b1);
    check_output("drain_valid", 64'(out_valid), 64'd0);
    check_output("drain_hold_y", 64'(y), 64'h5A);
    check_output("sweep_beat_cnt", 64'(beat_cnt), 64'd8);

    // Gate low forces zero
    apply_stimulus(1'b1, 8'hFF, 8'hFF, 3'd3, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'hFF, 8'hFF, 3'd3, 1'b1, 1'b1);
    check_output("gate_y", 64'(y), 64'h00);
    check_output("gate_valid", 64'(out_valid), 64'd1);
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    check_output("gate_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: three beats offered with out_ready low
    apply_stimulus(1'b1, 8'h0F, 8'hF0, 3'd1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h12, 8'h34, 3'd2, 1'b1, 1'b0);
    check_output("bp1_in_ready", 64'(in_ready), 64'd1);
    check_output("bp1_y", 64'(y), 64'hFF);
    apply_stimulus(1'b1, 8'h12, 8'h34, 3'd6, 1'b1, 1'b0);
    check_output("bp2_in_ready", 64'(in_ready), 64'd0);
    check_output("bp2_y", 64'(y), 64'hFF);
    apply_stimulus(1'b1, 8'h12, 8'h34, 3'd6, 1'b1, 1'b1);
    check_output("bp3_stall_in_ready", 64'(in_ready), 64'd0);
    check_output("bp3_beat_cnt", 64'(beat_cnt), 64'd11);
    check_output("bp3_y", 64'(y), 64'hFF);
    apply_stimulus(1'b1, 8'h12, 8'h34, 3'd6, 1'b1, 1'b1);
    check_output("bp4_y", 64'(y), 64'h26);
    check_output("bp4_in_ready", 64'(in_ready), 64'd1);
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    check_output("bp5_y", 64'(y), 64'h12);
    check_output("bp5_valid", 64'(out_valid), 64'd1);
    check_output("bp5_beat_cnt", 64'(beat_cnt), 64'd12);
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    check_output("bp_drain_valid", 64'(out_valid), 64'd0);
    check_output("bp_drain_y", 64'(y), 64'h12);

    // Counter wrap: fresh reset then 17 pushes with out_ready high
    rst_n = 1'b0;
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 8'(i), 8'h00, 3'd6, 1'b1, 1'b1);
    apply_stimulus(1'b1, 8'h00, 8'h00, 3'd6, 1'b1, 1'b1);
    check_output("wrap_cnt15", 64'(beat_cnt), 64'd15);
    check_output("wrap_y14", 64'(y), 64'h0E);
    apply_stimulus(1'b1, 8'h00, 8'h00, 3'd6, 1'b1, 1'b1);
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    check_output("wrap_cnt17", 64'(beat_cnt), 64'd1);

    // Mid-stream reset with two entries queued
    apply_stimulus(1'b1, 8'h81, 8'h00, 3'd6, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h7E, 8'h00, 3'd6, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    check_output("mid_full_in_ready", 64'(in_ready), 64'd0);
    check_output("mid_full_y", 64'(y), 64'h81);
`ifdef XNOR_GATE_PIPE_REDUCE_EN
    check_output("mid_y_zero", 64'(y_zero), 64'd0);
    check_output("mid_y_par", 64'(y_par), 64'd0);
`endif
    #1 rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 64'(out_valid), 64'd0);
    check_output("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_output("mid_rst_y", 64'(y), 64'h00);
    check_output("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
    #1 rst_n = 1'b1;
    apply_stimulus(1'b1, 8'hC3, 8'h3C, 3'd2, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    check_output("post_rst_y", 64'(y), 64'hFF);
    check_output("post_rst_valid", 64'(out_valid), 64'd1);
    check_output("post_rst_beat_cnt", 64'(beat_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
